load_align_unit: RTL

Sequential load path of the single-cycle core's data-memory interface, the read-side counterpart of the store formatter. It accepts one load at a time from the execute stage and issues a word-aligned read to data memory over a valid/ready request channel. It then waits for the response, extracts and sign- or zero-extends the addressed byte, halfword or word, and returns the result with a one-cycle done pulse. The core stalls on `loadBusy` while a load is in flight.

---
 rtl/load_align_unit_pkg.sv | 10 +
 rtl/load_extract.sv | 21 ++
 rtl/load_align_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: shared FSM states, load funct3 codes and default timeout
package load_align_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam int DEFAULT_TIMEOUT = 64;
endpackage

// File: rtl/load_extract.sv
// load_extract: selects and extends the addressed byte/halfword/word of a read word
// Ports: i_off byte offset addr[1:0], i_src funct3, i_word raw little-endian word, o_data extended result
module load_extract
  import load_align_unit_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_src,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_off[1] ? (i_off[0] ? i_word[31:24] : i_word[23:16])
                           : (i_off[0] ? i_word[15:8]  : i_word[7:0]);
  // odd halfword offsets fall back to the lane picked by addr[1]
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  assign o_data = (i_src == F3_LB)  ? {{24{w_byte[7]}}, w_byte} :
                  (i_src == F3_LBU) ? {24'b0, w_byte} :
                  (i_src == F3_LH)  ? {{16{w_half[15]}}, w_half} :
                  (i_src == F3_LHU) ? {16'b0, w_half} : i_word;
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load path issuing word reads and returning extended data
// Ports: clk/resetN (async active-low); loadReq/loadSrc/loadAddress from core; loadBusy, loadDone,
// loadData, loadError to core; memReqValid/memReqReady/memAddr request and memRspValid/memRspData response.
// Optional LOAD_MISALIGN_TRAP_EN: misaligned LH/LHU/LW bypass memory and complete with loadError.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        loadReq,
  input  logic [2:0]  loadSrc,
  input  logic [31:0] loadAddress,
  output logic        loadBusy,
  output logic        loadDone,
  output logic [31:0] loadData,
  output logic        loadError,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic [31:0] memAddr,
  input  logic        memRspValid,
  input  logic [31:0] memRspData
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_src;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic          w_misalign;
  logic [31:0]   w_ext;
`ifdef LOAD_MISALIGN_TRAP_EN
  assign w_misalign = (loadSrc == F3_LH || loadSrc == F3_LHU) ? loadAddress[0] :
                      (loadSrc == F3_LB || loadSrc == F3_LBU) ? 1'b0 : |loadAddress[1:0];
`else
  assign w_misalign = 1'b0;
`endif
  assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  load_extract u_extract (
    .i_off  (r_addr[1:0]),
    .i_src  (r_src),
    .i_word (memRspData),
    .o_data (w_ext)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = loadReq ? (w_misalign ? S_DONE : S_REQ) : S_IDLE;
      S_REQ:   w_next = memReqReady ? S_WAIT : S_REQ;
      S_WAIT:  w_next = (memRspValid || w_timeout) ? S_DONE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && loadReq) begin
        r_src  <= loadSrc;
        r_addr <= loadAddress;
        if (w_misalign) begin
          r_err  <= 1'b1;
          r_data <= '0;
        end
      end
      if (r_state == S_REQ && memReqReady) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        if (memRspValid) begin
          r_data <= w_ext;
          r_err  <= 1'b0;
        end else if (w_timeout) begin
          r_data <= '0;
          r_err  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
  assign loadBusy    = r_state != S_IDLE;
  assign loadDone    = r_state == S_DONE;
  assign memReqValid = r_state == S_REQ;
  assign memAddr     = {r_addr[31:2], 2'b00};
  assign loadData    = r_data;
  assign loadError   = r_err;
endmodule
